arith: RTL and testbench
========================

// Module: arith
// PURPOSE
//  Registered two's-complement adder/subtractor for the 8-bit datapath.
//  Computes a+b or a-b each clock, with carry-out and signed-overflow flags.
//  Sits between operand registers and the result bus; one-cycle latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk   in   1      single clock; all state updates on rising edge
//  rst   in   1      synchronous reset, active-high
//  a     in   WIDTH  operand A
//  b     in   WIDTH  operand B
//  sub   in   1      0: sum=a+b; 1: sum=a-b
//  sum   out  WIDTH  registered result
//  cout  out  1      registered carry out of MSB (sub: 1 = no borrow)
//  ov    out  1      registered signed overflow
//  zero  out  1      registered, 1 when sum==0
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - rst=1 at rising edge: sum=0, cout=0, ov=0, zero=0 next cycle; rst wins over inputs.
//  - Latency 1: inputs sampled at edge N appear on outputs after edge N. No handshake;
//    a new operation is accepted every cycle.
//  - Arithmetic: bx = sub ? ~b : b; {cout,sum} = a + bx + sub, computed WIDTH+1 wide.
//  - ov = (a[MSB]==bx[MSB]) && (sum[MSB]!=a[MSB]), computed on the unsaturated sum.
//  - Wrap-around: unsigned results wrap modulo 2^WIDTH; no saturation unless ARITH_SAT_EN.
//  - zero reflects the final registered sum, after saturation if enabled.
//  - Outputs change only at clock edges; a, b, sub are not registered separately.
// CONFIGURATION
//  ARITH_SAT_EN defined:
//   - on ov=1, sum saturates: positive overflow -> 0x7F..F, negative -> 0x80..0.
//   - ov and cout still report the raw, unsaturated condition.
//  ARITH_SAT_EN undefined: sum is the raw wrapped result.
// STRUCTURE
//  - arith_pkg: WIDTH default constant; OP_ADD=1'b0 / OP_SUB=1'b1 localparams;
//    SAT_POS/SAT_NEG helper constants.
//  - Sub-module arith_rca: combinational WIDTH-bit ripple-carry adder
//    (a, bx, cin -> s, cout, c_into_msb); instantiated once.
//  - Optional: ov = c_into_msb ^ cout.
//  - Top: operand inversion, overflow/saturation logic, output registers.
// TESTING
//  - rst=1 for 2 cycles with a=FF,b=FF -> sum=00,cout=0,ov=0,zero=0
//  - a=A5,b=5A,sub=0 -> sum=FF,cout=0,ov=0; a=11,b=11,sub=0 -> sum=22,cout=0,ov=0
//  - a=FF,b=02,sub=1 -> sum=FD,cout=1,ov=0; a=01,b=01,sub=1 -> sum=00,cout=1,zero=1
//  - a=A5,b=5A,sub=1 -> sum=4B,cout=1,ov=1 (with ARITH_SAT_EN: sum=80)
//  - a=FF,b=02,sub=0 -> sum=01,cout=1,ov=0; a=7F,b=01,sub=0 -> sum=80,ov=1 (SAT: 7F)
//  - Back-to-back ops every cycle, then rst asserted mid-stream -> outputs 0 next edge

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared width, opcode and saturation constants for the arith adder/subtractor
package arith_pkg;
  localparam int WIDTH = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
endpackage

// File: rtl/arith_rca.sv
// arith_rca: combinational WIDTH-bit ripple-carry adder (a, bx, cin -> s, cout, c_into_msb)
module arith_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] bx,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             c_into_msb
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  assign cout       = c[WIDTH];
  assign c_into_msb = c[WIDTH-1];
endmodule

// File: rtl/arith.sv
// arith: registered add/sub with carry, signed overflow and zero flags; saturation when ARITH_SAT_EN is defined
// ports: clk, rst (sync, active-high), a, b, sub (0 add, 1 sub) in; sum, cout, ov, zero registered out
module arith
  import arith_pkg::*;
#(
  parameter int WIDTH = arith_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov,
  output logic             zero
);
  logic [WIDTH-1:0] bx, s, res;
  logic co, cm, ovf;
  assign bx = (sub == OP_SUB) ? ~b : b;
  arith_rca #(.WIDTH(WIDTH)) u_rca (
    .a(a), .bx(bx), .cin(sub), .s(s), .cout(co), .c_into_msb(cm)
  );
  // carry into MSB differing from carry out is exactly signed overflow
  assign ovf = cm ^ co;
`ifdef ARITH_SAT_EN
  localparam logic [WIDTH-1:0] SP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SN = {1'b1, {(WIDTH-1){1'b0}}};
  // overflow direction follows the sign of a (both operands share it)
  assign res = ovf ? (a[WIDTH-1] ? SN : SP) : s;
`else
  assign res = s;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ov   <= 1'b0;
      zero <= 1'b0;
    end else begin
      sum  <= res;
      cout <= co;
      ov   <= ovf;
      zero <= (res == '0);
    end
  end
endmodule

// File: tb/tb_arith.sv
// tb_arith: directed self-checking bench for arith
module tb_arith;
  logic clk = 1'b0;
  logic rst, sub, cout, ov, zero;
  logic [7:0] a, b, sum;
  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] e;
    logic       c, o, z;
  } vec_t;

`ifdef ARITH_SAT_EN
  localparam logic [7:0] R_A5M5A = 8'h80;
  localparam logic [7:0] R_7FP01 = 8'h7F;
  localparam logic [7:0] R_80M01 = 8'h80;
`else
  localparam logic [7:0] R_A5M5A = 8'h4B;
  localparam logic [7:0] R_7FP01 = 8'h80;
  localparam logic [7:0] R_80M01 = 8'h7F;
`endif

  arith dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub),
    .sum(sum), .cout(cout), .ov(ov), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] ai, input logic [7:0] bi, input logic si);
    a = ai;
    b = bi;
    sub = si;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(8'hFF, 8'hFF, 1'b0);
    step(8'hFF, 8'hFF, 1'b0);
    vecs++;
    if ({sum, cout, ov, zero} !== 11'h0) begin
      errs++;
      $display("FAIL reset: got sum=%h c=%b o=%b z=%b, want sum=00 c=0 o=0 z=0", sum, cout, ov, zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    vec_t v[5];
    v[0] = {8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    v[1] = {8'h11, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
    v[2] = {8'hFF, 8'h02, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    v[3] = {8'h7F, 8'h01, 1'b0, R_7FP01, 1'b0, 1'b1, 1'b0};
    v[4] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(v[i].a, v[i].b, v[i].s);
      vecs++;
      if ({sum, cout, ov, zero} !== {v[i].e, v[i].c, v[i].o, v[i].z}) begin
        errs++;
        $display("FAIL add[%0d] %h+%h: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
                 i, v[i].a, v[i].b, sum, cout, ov, zero, v[i].e, v[i].c, v[i].o, v[i].z);
      end
    end
  endtask

  task automatic test_sub;
    vec_t v[5];
    v[0] = {8'hFF, 8'h02, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0};
    v[1] = {8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    v[2] = {8'hA5, 8'h5A, 1'b1, R_A5M5A, 1'b1, 1'b1, 1'b0};
    v[3] = {8'h80, 8'h01, 1'b1, R_80M01, 1'b1, 1'b1, 1'b0};
    v[4] = {8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(v[i].a, v[i].b, v[i].s);
      vecs++;
      if ({sum, cout, ov, zero} !== {v[i].e, v[i].c, v[i].o, v[i].z}) begin
        errs++;
        $display("FAIL sub[%0d] %h-%h: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
                 i, v[i].a, v[i].b, sum, cout, ov, zero, v[i].e, v[i].c, v[i].o, v[i].z);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[4];
    v[0] = {8'h11, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
    v[1] = {8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    v[2] = {8'hFF, 8'h02, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    v[3] = {8'hFF, 8'h02, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(v[i].a, v[i].b, v[i].s);
      vecs++;
      if ({sum, cout, ov, zero} !== {v[i].e, v[i].c, v[i].o, v[i].z}) begin
        errs++;
        $display("FAIL b2b[%0d]: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
                 i, sum, cout, ov, zero, v[i].e, v[i].c, v[i].o, v[i].z);
      end
    end
    rst = 1'b1;
    step(8'h7F, 8'h01, 1'b0);
    vecs++;
    if ({sum, cout, ov, zero} !== 11'h0) begin
      errs++;
      $display("FAIL b2b_rst: got sum=%h c=%b o=%b z=%b, want sum=00 c=0 o=0 z=0", sum, cout, ov, zero);
    end
    rst = 1'b0;
    step(8'h22, 8'h11, 1'b0);
    vecs++;
    if ({sum, cout, ov, zero} !== {8'h33, 1'b0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL b2b_resume: got sum=%h c=%b o=%b z=%b, want sum=33 c=0 o=0 z=0", sum, cout, ov, zero);
    end
  endtask

  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
